// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Owns the program counter and
//            assembles each 32-bit instruction from four byte reads on the
//            shared 8-bit RAM port (little-endian). A finished instruction is
//            offered to the IF/ID register with a valid/ready handshake.
//            A branch redirect from EX aborts any fetch in progress.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W    PC / byte-address width
//   RESET_PC  PC value loaded by reset
// Ports
//   clk               in   1       system clock, rising edge
//   rst               in   1       asynchronous, active-low reset
//   branch_flag_i     in   1       redirect pulse from EX
//   branch_addr_i     in   ADDR_W  redirect target
//   mem_grant_i       in   1       arbiter grants the RAM port this cycle
//   mem_data_i        in   8       read byte, valid the cycle after a grant
//   mem_rd_o          out  1       byte read request
//   mem_addr_o        out  ADDR_W  byte address of the request
//   inst_ready_i      in   1       IF/ID accepts the instruction
//   inst_valid_o      out  1       inst_o / inst_pc_o hold a full instruction
//   inst_o            out  32      fetched instruction
//   inst_pc_o         out  ADDR_W  address of inst_o
//   perf_inst_cnt_o   out  32      completed handshakes   (IF_FETCH_PERF_EN)
//   perf_flush_cnt_o  out  32      branch pulses seen      (IF_FETCH_PERF_EN)
// Build option
//   IF_FETCH_PERF_EN  when defined, adds the two performance counters.
// ============================================================================
module if_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              mem_grant_i,
    input  logic [7:0]        mem_data_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              inst_ready_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_inst_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic [2:0]        issue_cnt_q,  issue_cnt_d;   // requests issued, 0..4
    logic              pend_q,       pend_d;        // a byte returns this cycle
    logic [1:0]        pend_idx_q,   pend_idx_d;    // which byte lane it fills
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q,       inst_d;
    logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;
    logic              req_taken;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            issue_cnt_q  <= 3'd0;
            pend_q       <= 1'b0;
            pend_idx_q   <= 2'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issue_cnt_q  <= issue_cnt_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Request generation and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Request side: issue_cnt_q[2] set means all four bytes are out.
        mem_rd_o   = (state_q == FETCH) && !issue_cnt_q[2];
        mem_addr_o = pc_q + {{(ADDR_W-3){1'b0}}, issue_cnt_q};
        req_taken  = mem_rd_o && mem_grant_i;

        state_d      = state_q;
        pc_d         = pc_q;
        issue_cnt_d  = issue_cnt_q;
        pend_d       = 1'b0;
        pend_idx_d   = pend_idx_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;

        if (branch_flag_i) begin
            // Redirect wins over everything; clearing pend drops any byte
            // still in flight from the aborted fetch.
            state_d      = FETCH;
            pc_d         = branch_addr_i;
            issue_cnt_d  = 3'd0;
            pend_d       = 1'b0;
            inst_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end

                FETCH: begin
                    if (req_taken) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                        pend_d      = 1'b1;
                        pend_idx_d  = issue_cnt_q[1:0];
                    end
                    if (pend_q) begin
                        inst_d[{pend_idx_q, 3'b000} +: 8] = mem_data_i;
                        // The top byte closes the fetch.
                        if (pend_idx_q == 2'd3) begin
                            inst_valid_d = 1'b1;
                            inst_pc_d    = pc_q;
                            state_d      = HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (inst_ready_i) begin
                        inst_valid_d = 1'b0;
                        pc_d         = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
                        issue_cnt_d  = 3'd0;
                        state_d      = FETCH;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

`ifdef IF_FETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------------
    logic [31:0] perf_inst_cnt_q;
    logic [31:0] perf_flush_cnt_q;
    logic        handshake;

    // A handshake completing together with a branch still counts as consumed.
    assign handshake = (state_q == HOLD) && inst_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_inst_cnt_q  <= 32'd0;
            perf_flush_cnt_q <= 32'd0;
        end else begin
            if (handshake) begin
                perf_inst_cnt_q <= perf_inst_cnt_q + 32'd1;
            end
            if (branch_flag_i) begin
                perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_inst_cnt_o  = perf_inst_cnt_q;
    assign perf_flush_cnt_o = perf_flush_cnt_q;
`endif

endmodule
`default_nettype wire
